// File: rtl/stream_mux_pkg.sv
// rtl/stream_mux_pkg.sv - shared types and helpers for the round-robin stream mux
package stream_mux_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    function automatic int sel_w(input int n);
        return ($clog2(n) > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational rotate-priority search starting just after ptr
module rr_arbiter #(
    parameter int N     = 4,
    parameter int SEL_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] ptr,
    output logic             gnt_valid,
    output logic [SEL_W-1:0] gnt_idx
);

    localparam int NP = 2 ** SEL_W;

    logic [NP-1:0] req_ext;

    // Walk from the farthest offset down so the nearest requester after ptr wins.
    always_comb begin
        req_ext        = '0;
        req_ext[N-1:0] = req;
        gnt_valid      = 1'b0;
        gnt_idx        = '0;
        for (int k = N; k >= 1; k--) begin
            if (req_ext[SEL_W'((int'(ptr) + k) % N)]) begin
                gnt_valid = 1'b1;
                gnt_idx   = SEL_W'((int'(ptr) + k) % N);
            end
        end
    end

endmodule

// File: rtl/stream_mux_rr.sv
// rtl/stream_mux_rr.sv - N:1 packet stream mux, round-robin, registered output
// Optional STREAM_MUX_FORCE_SEL_EN adds force_en/force_sel to pin the IDLE grant.
module stream_mux_rr
    import stream_mux_pkg::*;
#(
    parameter int N_IN  = 4,
    parameter int WIDTH = 8,
    parameter int SEL_W = sel_w(N_IN)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_IN*WIDTH-1:0]   in_data,
    input  logic [N_IN-1:0]         in_valid,
    input  logic [N_IN-1:0]         in_last,
    output logic [N_IN-1:0]         in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    output logic                    out_last,
    output logic [SEL_W-1:0]        out_sel,
`ifdef STREAM_MUX_FORCE_SEL_EN
    input  logic                    out_ready,
    input  logic                    force_en,
    input  logic [SEL_W-1:0]        force_sel
`else
    input  logic                    out_ready
`endif
);

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   grant_q, grant_d;
    logic [SEL_W-1:0]   ptr_q, ptr_d;
    logic [WIDTH-1:0]   out_data_q, out_data_d;
    logic               out_valid_q, out_valid_d;
    logic               out_last_q, out_last_d;
    logic [SEL_W-1:0]   out_sel_q, out_sel_d;

    logic [N_IN-1:0]    arb_req;
    logic               keep_ptr;
    logic               arb_gnt_valid;
    logic [SEL_W-1:0]   arb_gnt_idx;

    logic [WIDTH-1:0]   sel_data;
    logic               sel_valid;
    logic               sel_last;
    logic               can_accept;
    logic               load;

    always_comb begin
        sel_data  = '0;
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        for (int i = 0; i < N_IN; i++) begin
            if (grant_q == SEL_W'(i)) begin
                sel_data  = in_data[i*WIDTH +: WIDTH];
                sel_valid = in_valid[i];
                sel_last  = in_last[i];
            end
        end
    end

    // A forced choice leaves ptr alone so the round-robin order resumes untouched.
    always_comb begin
        arb_req  = in_valid;
        keep_ptr = 1'b0;
`ifdef STREAM_MUX_FORCE_SEL_EN
        if (force_en) begin
            keep_ptr = 1'b1;
            arb_req  = '0;
            for (int i = 0; i < N_IN; i++) begin
                if (force_sel == SEL_W'(i)) begin
                    arb_req[i] = in_valid[i];
                end
            end
        end
`endif
    end

    rr_arbiter #(
        .N     (N_IN),
        .SEL_W (SEL_W)
    ) u_arb (
        .req       (arb_req),
        .ptr       (ptr_q),
        .gnt_valid (arb_gnt_valid),
        .gnt_idx   (arb_gnt_idx)
    );

    assign can_accept = !out_valid_q || out_ready;
    assign load       = (state_q == LOCKED) && sel_valid && can_accept;

    always_comb begin
        in_ready = '0;
        if (state_q == LOCKED && can_accept) begin
            for (int i = 0; i < N_IN; i++) begin
                if (grant_q == SEL_W'(i)) begin
                    in_ready[i] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (arb_gnt_valid) begin
                    grant_d = arb_gnt_idx;
                    state_d = LOCKED;
                    if (!keep_ptr) begin
                        ptr_d = arb_gnt_idx;
                    end
                end
            end
            LOCKED: begin
                if (load && sel_last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_sel_d   = out_sel_q;
        if (load) begin
            out_data_d  = sel_data;
            out_valid_d = 1'b1;
            out_last_d  = sel_last;
            out_sel_d   = grant_q;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            ptr_q       <= SEL_W'(N_IN - 1);
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_sel_q   <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            ptr_q       <= ptr_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_sel_q   <= out_sel_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// tb/tb_stream_mux_rr.sv - randomized and directed bench for stream_mux_rr against a reference model
module tb_stream_mux_rr;

    localparam int N = 4;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N*W-1:0] in_data = '0;
    logic [N-1:0]   in_valid = '0;
    logic [N-1:0]   in_last = '0;
    logic [N-1:0]   in_ready;
    logic [W-1:0]   out_data;
    logic           out_valid;
    logic           out_last;
    logic [1:0]     out_sel;
    logic           out_ready = 1'b0;
`ifdef STREAM_MUX_FORCE_SEL_EN
    logic           force_en = 1'b0;
    logic [1:0]     force_sel = '0;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Per-channel beat source: {last, data}
    logic [8:0] buf_mem [N][512];
    int         head [N];
    int         tail [N];

    // Reference model: owner is the locked channel, -1 while arbitrating
    int         m_owner = -1;
    int         m_ptr   = N - 1;
    logic       m_valid = 1'b0;
    logic       m_last  = 1'b0;
    logic [7:0] m_data  = '0;
    int         m_sel   = 0;

    int         log_sel [64];
    logic [7:0] log_data [64];
    int         n_log = 0;

    logic [N-1:0] dut_rdy;
    logic         pre_take;
    int           pre_sel;
    logic [7:0]   pre_data;

    always #5 clk = ~clk;

    stream_mux_rr #(.N_IN(N), .WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_last  (out_last),
        .out_sel   (out_sel),
`ifdef STREAM_MUX_FORCE_SEL_EN
        .out_ready (out_ready),
        .force_en  (force_en),
        .force_sel (force_sel)
`else
        .out_ready (out_ready)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [N-1:0] exp_ready();
        logic [N-1:0] r;
        r = '0;
        if (m_owner >= 0 && (!m_valid || out_ready)) r[m_owner] = 1'b1;
        return r;
    endfunction

    task automatic model_edge();
        int   own;
        logic acc;
        logic use_force;
        if (rst) begin
            m_owner = -1; m_ptr = N - 1;
            m_valid = 1'b0; m_last = 1'b0; m_data = '0; m_sel = 0;
            return;
        end
        own = m_owner;
        acc = (own >= 0) && in_valid[own] && (!m_valid || out_ready);
        if (acc) begin
            m_data  = in_data[own*W +: W];
            m_last  = in_last[own];
            m_sel   = own;
            m_valid = 1'b1;
            if (in_last[own]) m_owner = -1;
        end else if (out_ready) begin
            m_valid = 1'b0;
        end
        if (own < 0) begin
            use_force = 1'b0;
`ifdef STREAM_MUX_FORCE_SEL_EN
            use_force = force_en;
            if (force_en && int'(force_sel) < N && in_valid[force_sel]) m_owner = int'(force_sel);
`endif
            if (!use_force) begin
                for (int k = 1; k <= N; k++) begin
                    if (in_valid[(m_ptr + k) % N]) begin
                        m_owner = (m_ptr + k) % N;
                        m_ptr   = m_owner;
                        break;
                    end
                end
            end
        end
    endtask

    task automatic push_pkt(input int c, input int len);
        for (int b = 0; b < len; b++) begin
            buf_mem[c][tail[c]] = {(b == len - 1), 8'($urandom)};
            tail[c]++;
        end
    endtask

    task automatic drive(input int vpct, input int rpct, input logic [N-1:0] mask);
        logic [8:0] d;
        for (int c = 0; c < N; c++) begin
            d = (head[c] < tail[c]) ? buf_mem[c][head[c]] : {1'b0, 8'($urandom)};
            in_valid[c] = (head[c] < tail[c]) && mask[c] && (int'($urandom_range(99)) < vpct);
            in_data[c*W +: W] = d[7:0];
            in_last[c] = d[8];
        end
        out_ready = int'($urandom_range(99)) < rpct;
    endtask

    task automatic step();
        #1;
        chk("in_ready", 32'(in_ready), 32'(exp_ready()));
        dut_rdy  = in_ready;
        pre_take = out_valid && out_ready;
        pre_sel  = int'(out_sel);
        pre_data = out_data;
        @(posedge clk);
        model_edge();
        for (int c = 0; c < N; c++) begin
            if (!rst && in_valid[c] && dut_rdy[c]) head[c]++;
        end
        if (pre_take && !rst && n_log < 64) begin
            log_sel[n_log]  = pre_sel;
            log_data[n_log] = pre_data;
            n_log++;
        end
        #1;
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        chk("out_data", 32'(out_data), 32'(m_data));
        chk("out_last", 32'(out_last), 32'(m_last));
        chk("out_sel", 32'(out_sel), 32'(m_sel));
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = '0; out_ready = 1'b1;
        step();
        step();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_sel", 32'(out_sel), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        rst = 1'b0;
        for (int c = 0; c < N; c++) begin head[c] = 0; tail[c] = 0; end
        n_log = 0;
    endtask

    task automatic run_until(input string tag, input int target, input int budget,
                             input int rpct, input logic [N-1:0] mask);
        int cyc;
        cyc = 0;
        while (n_log < target && cyc < budget) begin
            drive(100, rpct, mask);
            step();
            cyc++;
        end
        chk(tag, 32'(n_log >= target), 32'd1);
    endtask

    initial begin
        int exp_rr [5];
        logic [7:0] held;
        logic all_empty;
        exp_rr = '{0, 1, 2, 3, 0};
        for (int c = 0; c < N; c++) begin head[c] = 0; tail[c] = 0; end
        @(posedge clk);
        #1;

        // Round-robin order with single-beat packets
        do_reset();
        for (int c = 0; c < N; c++) for (int p = 0; p < 3; p++) push_pkt(c, 1);
        run_until("rr_timeout", 5, 60, 100, 4'hF);
        for (int i = 0; i < 5; i++) chk("rr_order", 32'(log_sel[i]), 32'(exp_rr[i]));

        // Packet lock: ch1 three beats before ch2
        do_reset();
        push_pkt(1, 3);
        push_pkt(2, 1);
        run_until("lock_timeout", 4, 40, 100, 4'hF);
        for (int i = 0; i < 3; i++) begin
            chk("lock_sel", 32'(log_sel[i]), 32'd1);
            chk("lock_data", 32'(log_data[i]), 32'(buf_mem[1][i][7:0]));
        end
        chk("lock_next", 32'(log_sel[3]), 32'd2);

        // Backpressure mid-packet
        do_reset();
        push_pkt(0, 6);
        for (int i = 0; i < 3; i++) begin drive(100, 100, 4'hF); step(); end
        held = out_data;
        for (int i = 0; i < 5; i++) begin
            drive(100, 0, 4'hF);
            step();
            chk("bp_hold", 32'(out_data), 32'(held));
            chk("bp_ready", 32'(in_ready), 32'd0);
        end
        run_until("bp_timeout", 6, 30, 100, 4'hF);
        for (int i = 0; i < 6; i++) chk("bp_data", 32'(log_data[i]), 32'(buf_mem[0][i][7:0]));
        for (int i = 0; i < 4; i++) begin drive(100, 100, 4'hF); step(); end
        chk("bp_count", 32'(n_log), 32'd6);

        // Gap on the granted channel while another waits
        do_reset();
        push_pkt(1, 3);
        push_pkt(2, 2);
        for (int i = 0; i < 20 && head[1] < 1; i++) begin drive(100, 100, 4'hF); step(); end
        chk("gap_start", 32'(head[1]), 32'd1);
        for (int i = 0; i < 2; i++) begin
            drive(100, 100, 4'b1101);
            step();
            chk("gap_ready", 32'(in_ready), 32'b0010);
        end
        run_until("gap_timeout", 5, 40, 100, 4'hF);
        for (int i = 0; i < 3; i++) chk("gap_sel", 32'(log_sel[i]), 32'd1);
        chk("gap_next", 32'(log_sel[3]), 32'd2);

`ifdef STREAM_MUX_FORCE_SEL_EN
        do_reset();
        for (int c = 0; c < N; c++) for (int p = 0; p < 2; p++) push_pkt(c, 1);
        force_en = 1'b1; force_sel = 2'd2;
        run_until("force_timeout", 1, 20, 100, 4'hF);
        chk("force_sel", 32'(log_sel[0]), 32'd2);
        for (int i = 0; i < 6; i++) begin drive(100, 100, 4'b1011); step(); end
        chk("force_nogrant", 32'(n_log), 32'd1);
        chk("force_ready", 32'(in_ready), 32'd0);
        force_en = 1'b0;
        run_until("force_resume", 2, 20, 100, 4'hF);
        chk("force_ptr", 32'(log_sel[1]), 32'd0);
`endif

        // Random traffic with a reset in the middle
        do_reset();
        for (int c = 0; c < N; c++) for (int p = 0; p < 20; p++) push_pkt(c, int'($urandom_range(4, 1)));
        for (int i = 0; i < 800; i++) begin
            rst = (i == 400 || i == 401);
            drive(70, 60, 4'hF);
            step();
            if (i == 401) begin
                chk("mid_rst_valid", 32'(out_valid), 32'd0);
                chk("mid_rst_sel", 32'(out_sel), 32'd0);
                chk("mid_rst_ready", 32'(in_ready), 32'd0);
            end
        end
        rst = 1'b0;
        all_empty = 1'b0;
        for (int i = 0; i < 3000 && !all_empty; i++) begin
            drive(100, 100, 4'hF);
            step();
            all_empty = !out_valid;
            for (int c = 0; c < N; c++) if (head[c] < tail[c]) all_empty = 1'b0;
        end
        chk("drain", 32'(all_empty), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
